// File: rtl/max_argmax_tree.sv
// max_argmax_tree: pipelined max/min reduction over N lanes returning the winning value and its lane index.
// Output backpressure freezes every stage at once.
module max_argmax_tree #(
    parameter int DATA_W = 32,
    parameter int N = 10,
    parameter bit SIGNED = 1'b0,
    localparam int L = $clog2(N),
    localparam int IDX_W = (L > 0) ? L : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mode_min,
    input  logic [N*DATA_W-1:0] d_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   d_out,
    output logic [IDX_W-1:0]    idx_out
);
    localparam int MW = (L > 0) ? L : 1;

    function automatic int cnt(input int k);
        return (N + (1 << k) - 1) >> k;
    endfunction

    logic          stall;
    logic [L:0]    vld;
    logic [MW-1:0] mode_q;

    assign stall     = vld[L] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld[L];

    // mode_q[k] is the frame mode steering the compares that produce level k+1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld    <= '0;
            mode_q <= '0;
        end else if (!stall) begin
            vld[0] <= in_valid;
            for (int i = 1; i <= L; i++) vld[i] <= vld[i-1];
            if (in_valid) mode_q[0] <= mode_min;
            for (int i = 1; i < MW; i++) mode_q[i] <= mode_q[i-1];
        end
    end

    for (genvar k = 0; k <= L; k++) begin : lvl
        localparam int C = cnt(k);
        logic [DATA_W-1:0] v  [C];
        logic [IDX_W-1:0]  ix [C];
        if (k == 0) begin : g_in
            for (genvar j = 0; j < C; j++) begin : g_ix
                assign ix[j] = IDX_W'(j);
            end
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    v <= '{default: '0};
                else if (!stall && in_valid)
                    for (int i = 0; i < C; i++) v[i] <= d_in[i*DATA_W +: DATA_W];
            end
        end else begin : g_lvl
            localparam int P = cnt(k - 1);
            logic [DATA_W-1:0] nv [C];
            logic [IDX_W-1:0]  ni [C];
            for (genvar j = 0; j < C; j++) begin : g_node
                if (2 * j + 1 < P) begin : g_cmp
                    logic [DATA_W-1:0] a;
                    logic [DATA_W-1:0] b;
                    logic              gt;
                    logic              lt;
                    logic              take_b;
                    assign a = lvl[k-1].v[2*j];
                    assign b = lvl[k-1].v[2*j+1];
                    assign gt = SIGNED ? ($signed(b) > $signed(a)) : (b > a);
                    assign lt = SIGNED ? ($signed(b) < $signed(a)) : (b < a);
                    // strict compare: ties keep the left (lower-index) entry
                    assign take_b = mode_q[k-1] ? lt : gt;
                    assign nv[j] = take_b ? b : a;
                    assign ni[j] = take_b ? lvl[k-1].ix[2*j+1] : lvl[k-1].ix[2*j];
                end else begin : g_pass
                    assign nv[j] = lvl[k-1].v[2*j];
                    assign ni[j] = lvl[k-1].ix[2*j];
                end
            end
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v  <= '{default: '0};
                    ix <= '{default: '0};
                end else if (!stall) begin
                    v  <= nv;
                    ix <= ni;
                end
            end
        end
    end

    assign d_out   = lvl[L].v[0];
    assign idx_out = lvl[L].ix[0];
endmodule

// File: tb/tb_max_argmax_tree.sv
// tb_max_argmax_tree: scoreboard bench for three max_argmax_tree configurations.
// u_main is the backpressured reference; u_sgn and u_n5 always drain.
module tb_max_argmax_tree;
    localparam int W = 32;

    typedef struct {
        logic [63:0] e;
        int          c;
        int          s;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            mode_min = 1'b0;
    logic            out_ready = 1'b1;
    logic [10*W-1:0] d_in = '0;
    logic            ir0, ir1, ir2, ov0, ov1, ov2;
    logic [W-1:0]    d0, d1, d2;
    logic [3:0]      i0, i1;
    logic [2:0]      i2;

    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int           stalls [3];
    logic [W-1:0] pd [3];
    logic [3:0]   pi [3];
    bit           pst [3];
    bit           done;
    logic [W-1:0] a [10];
    logic [10*W-1:0] fr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    max_argmax_tree #(.DATA_W(W), .N(10), .SIGNED(1'b0)) u_main (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .mode_min(mode_min),
        .d_in(d_in), .out_valid(ov0), .out_ready(out_ready), .d_out(d0), .idx_out(i0));
    max_argmax_tree #(.DATA_W(W), .N(10), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .mode_min(mode_min),
        .d_in(d_in), .out_valid(ov1), .out_ready(1'b1), .d_out(d1), .idx_out(i1));
    max_argmax_tree #(.DATA_W(W), .N(5), .SIGNED(1'b0)) u_n5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .mode_min(mode_min),
        .d_in(d_in[5*W-1:0]), .out_valid(ov2), .out_ready(1'b1), .d_out(d2), .idx_out(i2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit less(input logic [W-1:0] x, input logic [W-1:0] y, input bit sg);
        return sg ? ($signed(x) < $signed(y)) : (x < y);
    endfunction

    // linear scan, strict improvement only, so the lowest index wins ties
    function automatic logic [63:0] model(input logic [10*W-1:0] d, input bit mn, input bit sg, input int n);
        logic [W-1:0] best;
        logic [W-1:0] x;
        int bi;
        best = d[W-1:0];
        bi = 0;
        for (int i = 1; i < n; i++) begin
            x = d[i*W +: W];
            if (mn ? less(x, best, sg) : less(best, x, sg)) begin
                best = x;
                bi = i;
            end
        end
        return {bi, best};
    endfunction

    function automatic int qsize(input int u);
        return (u == 0) ? q0.size() : (u == 1) ? q1.size() : q2.size();
    endfunction

    task automatic qpush(input int u, input exp_t x);
        if (u == 0) q0.push_back(x);
        else if (u == 1) q1.push_back(x);
        else q2.push_back(x);
    endtask

    task automatic qpop(input int u, output exp_t x);
        if (u == 0) x = q0.pop_front();
        else if (u == 1) x = q1.pop_front();
        else x = q2.pop_front();
    endtask

    task automatic mon(input int u, input int lat, input int n, input bit sg, input logic irv,
                       input logic ovv, input logic orv, input logic [W-1:0] dv, input logic [3:0] iv);
        exp_t x;
        if (pst[u]) begin
            check($sformatf("hold_d%0d", u), dv, pd[u]);
            check($sformatf("hold_idx%0d", u), iv, pi[u]);
            check($sformatf("hold_valid%0d", u), ovv, 1);
        end
        if (ovv && orv) begin
            if (qsize(u) == 0) check($sformatf("unexpected_out%0d", u), ovv, 0);
            else begin
                qpop(u, x);
                check($sformatf("d%0d", u), dv, x.e[31:0]);
                check($sformatf("idx%0d", u), iv, x.e[35:32]);
                check($sformatf("lat%0d", u), cyc - x.c, lat + stalls[u] - x.s);
            end
        end
        pst[u] = ovv && !orv;
        if (pst[u]) begin
            stalls[u]++;
            pd[u] = dv;
            pi[u] = iv;
            check($sformatf("stall_ready%0d", u), irv, 0);
        end
        if (in_valid && irv) qpush(u, '{model(d_in, mode_min, sg, n), cyc, stalls[u]});
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon(0, 5, 10, 1'b0, ir0, ov0, out_ready, d0, i0);
            mon(1, 5, 10, 1'b1, ir1, ov1, 1'b1, d1, i1);
            mon(2, 4, 5, 1'b0, ir2, ov2, 1'b1, d2, {1'b0, i2});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [10*W-1:0] f, input logic m);
        int guard;
        guard = 0;
        d_in = f;
        mode_min = m;
        in_valid = 1'b1;
        @(negedge clk);
        while (!ir0 && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (guard == 50) check("accept_timeout", ir0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    function automatic logic [10*W-1:0] pack(input logic [W-1:0] v [10]);
        logic [10*W-1:0] r;
        for (int i = 0; i < 10; i++) r[i*W +: W] = v[i];
        return r;
    endfunction

    function automatic logic [10*W-1:0] rnd_frame();
        logic [10*W-1:0] r;
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 2))
                0: r[i*W +: W] = W'($urandom_range(0, 3));
                1: r[i*W +: W] = 32'hFFFF_FFF0 + W'($urandom_range(0, 3));
                default: r[i*W +: W] = W'($urandom);
            endcase
        end
        return r;
    endfunction

    task automatic clear_sb();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int i = 0; i < 3; i++) pst[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            stalls[i] = 0;
            pst[i] = 1'b0;
        end
        in_valid = 1'b1;
        d_in = {10{32'h0000_00AA}};
        repeat (3) begin
            @(negedge clk);
            check("rst_valid", ov0, 0);
            check("rst_d", d0, 0);
            check("rst_idx", i0, 0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        in_valid = 1'b0;
        #1 check("rst_ready", ir0, 1);
        idle(1);

        a = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        send(pack(a), 1'b0);
        idle(6);
        send(pack(a), 1'b1);
        idle(6);
        a = '{32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'hFFFF_FFFF, 32'h10, 32'h10};
        send(pack(a), 1'b0);
        send(pack(a), 1'b1);
        idle(6);
        a = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 100};
        send(pack(a), 1'b0);
        a = '{0, 0, 0, 0, 100, 0, 0, 0, 0, 0};
        send(pack(a), 1'b0);
        send(pack(a), 1'b1);
        idle(6);

        fork
            begin
                for (int f = 0; f < 6; f++) send(rnd_frame(), f[0]);
            end
            begin
                int g;
                g = 0;
                @(negedge clk);
                while (!ov0 && g < 30) begin
                    g++;
                    @(negedge clk);
                end
                if (g == 30) check("bp_out_timeout", ov0, 1);
                @(posedge clk);
                #1 out_ready = 1'b0;
                idle(3);
                out_ready = 1'b1;
            end
        join
        idle(8);

        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 30; f++) begin
                    if ($urandom_range(0, 3) == 0) idle(1);
                    send(rnd_frame(), 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        idle(12);

        fr = rnd_frame();
        send(fr, 1'b0);
        send(rnd_frame(), 1'b1);
        send(rnd_frame(), 1'b0);
        idle(2);
        check("pre_rst_valid", ov0, 1);
        #1 rst = 1'b0;
        clear_sb();
        #1 check("async_rst_valid", ov0, 0);
        check("async_rst_d", d0, 0);
        check("async_rst_idx", i0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(8);
        send(fr, 1'b1);
        idle(10);

        check("drain_main", qsize(0), 0);
        check("drain_sgn", qsize(1), 0);
        check("drain_n5", qsize(2), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/max_argmax_tree.md
Name: max_argmax_tree

Overview:
- Parametrised pipelined reduction tree that returns the maximum (or minimum) of N packed inputs and the index of the winning lane.
- Successor to the fixed 10-input, 32-bit max block. Adds generic width and lane count, signed/unsigned compare, per-frame max/min mode, argmax index output, and output backpressure.
- Sits after the classifier/score datapath and feeds decision logic; one frame of N values is accepted per handshake.

Parameters:
- DATA_W, 32, bit width of each lane value.
- N, 10, number of lanes (N >= 1).
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare.
- IDX_W, derived = max(1, clog2(N)), width of the index output (localparam, not overridable).
- L, derived = clog2(N), number of tree levels (localparam).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  frame on d_in is valid.
- in_ready  out  1  block can accept a frame this cycle.
- mode_min  in  1  0 = max, 1 = min; sampled with the frame.
- d_in  in  N*DATA_W  packed lanes; lane i = d_in[i*DATA_W +: DATA_W].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- d_out  out  DATA_W  winning value.
- idx_out  out  IDX_W  lane index of the winning value.

Behaviour:
- Reset (rst=0, asynchronous):
  - All pipeline valids clear; out_valid=0, d_out=0, idx_out=0.
  - in_ready=1 once the pipeline valids are clear.
  - Any in-flight frames are discarded, with no partial output.
- Stall rule: stall = out_valid & ~out_ready; in_ready = ~stall.
  - While stalled, every stage register (data, index, mode, valid) holds its value.
  - This is a global freeze: no bubble compaction.
- Stage 0 (input register):
  - On an edge with in_ready & in_valid, captures all N lanes, indices 0..N-1 and mode_min; valid0 is set to 1.
  - On an edge with in_ready & ~in_valid, valid0 is set to 0 and the data registers hold their previous value.
- Tree levels 1..L:
  - Level k pairs adjacent entries of level k-1: (0,1), (2,3), ...
  - An unpaired last entry passes through unchanged with its index.
  - Each level is registered. Valid and mode shift along with the data.
- Compare:
  - Signed or unsigned per SIGNED.
  - Max mode: pick the right entry only if right > left.
  - Min mode: pick the right entry only if right < left.
  - Ties always keep the left entry, so the lowest lane index wins.
- Output: the level-L register drives d_out, idx_out and out_valid directly, with no combinational output path. For N=1 the stage-0 register is the output.
- Latency:
  - A frame accepted in cycle t appears with out_valid=1 in cycle t+L+1 (N=10: t+5), absent stalls.
  - Each stall cycle adds one cycle.
- Throughput: one frame per cycle when out_ready=1.
- Output hold: once out_valid=1, d_out/idx_out/out_valid stay stable until the cycle in which out_ready=1.
- out_ready is ignored when out_valid=0; that case is not a stall.
- Simultaneous in_valid and stall: the frame is not accepted (in_ready=0). The source must hold it.
- No wrap or overflow: a compare-select never modifies values.

Test Plan:
- Reset: rst=0 for 3 cycles with in_valid=1 -> out_valid=0, d_out=0, idx_out=0. After release, in_ready=1 and the first output appears exactly 5 cycles after the first accepted frame.
- Basic max (N=10, DATA_W=32, SIGNED=0): lanes 0..9 = 3,1,4,1,5,9,2,6,5,3, mode_min=0 -> d_out=9, idx_out=5 at t+5. Same frame with mode_min=1 -> d_out=1, idx_out=1 (tie between lanes 1 and 3; lowest index wins).
- Signedness: lane 7=0xFFFF_FFFF, all other lanes 0x0000_0010. SIGNED=0 -> d_out=0xFFFF_FFFF, idx_out=7. SIGNED=1 -> d_out=0x10, idx_out=0.
- Odd pass-through: lane 9=100, all other lanes 0, max mode -> d_out=100, idx_out=9. Repeat with N=5, lane 4 max -> idx_out=4 at t+4.
- Backpressure: 6 back-to-back frames, out_ready=0 for 3 cycles after the first out_valid -> in_ready=0 during the stall, output held stable, and all 6 results emerge in order with no loss or duplication.
- Reset mid-flight: 3 frames in flight, rst pulsed low for 1 cycle -> out_valid drops immediately (asynchronously), none of the 3 results ever appear, and the next frame after release has latency 5.
